// File: rtl/load_unit.sv
// load_unit: multicycle load path from the datapath to a synchronous data memory.
// Accepts one load at a time, issues a single word-aligned read, then extracts and
// sign/zero-extends the addressed byte, halfword or word. Misaligned and illegal
// loads are answered directly without a memory access.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and req_ready=1;
// the requester holds req_addr/req_funct3 stable until then. resp_valid is a one-cycle
// strobe with no back-pressure; resp_data and the flags hold until the next response.
module load_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rd_data,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_misaligned,
    output logic                  resp_illegal,
    output logic [1:0]            dbg_state
);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
            $error("load_unit: MEM_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

    state_t                state_q, state_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic                  resp_mis_q, resp_mis_d;
    logic                  resp_ill_q, resp_ill_d;

    // Request decode: illegal funct3 codes and alignment violations.
    logic req_illegal;
    logic req_misaligned;
    assign req_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

    // Lane selection from the returned word using the registered byte offset.
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_result;
    assign shifted = mem_rd_data >> {off_q, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = off_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

    // Extension by load type.
    always_comb begin
        load_result = mem_rd_data;
        case (funct3_q)
            3'b000:  load_result = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_result = {{16{half_v[15]}}, half_v};
            3'b100:  load_result = {24'h0, byte_v};
            3'b101:  load_result = {16'h0, half_v};
            default: load_result = mem_rd_data;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        req_ready_d  = 1'b0;
        mem_rd_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_mis_d   = resp_mis_q;
        resp_ill_d   = resp_ill_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    if (req_illegal || req_misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = 32'h0;
                        resp_ill_d   = req_illegal;
                        resp_mis_d   = req_misaligned;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_result;
                    resp_mis_d   = 1'b0;
                    resp_ill_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            cnt_q        <= 2'b00;
            req_ready_q  <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_mis_q   <= resp_mis_d;
            resp_ill_q   <= resp_ill_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign mem_rd_en       = mem_rd_en_q;
    assign mem_addr        = mem_addr_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_illegal    = resp_ill_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/load_unit.md
# load_unit

Multicycle load path between the processor datapath and the synchronous data memory; the read-side counterpart of the store path that drives `mem_write`, `alu_result` and `rs2_data`. It accepts one load request at a time from the control FSM and issues a single word-aligned read. It then extracts and sign- or zero-extends the addressed byte, halfword or word for the register-file writeback mux. Misaligned and illegal loads are flagged without touching memory.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width.
- `MEM_LATENCY`, default 1: cycles from `mem_rd_en` to valid `mem_rd_data`. Legal range is 1..4; out-of-range values are an elaboration error.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  load request from the control FSM.
- `req_ready`  out  1  unit can accept a request.
- `req_addr`  in  ADDR_WIDTH  byte address (ALU result).
- `req_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `mem_rd_en`  out  1  one-cycle read strobe.
- `mem_addr`  out  ADDR_WIDTH  word address, `req_addr` with bits [1:0] cleared.
- `mem_rd_data`  in  32  read word, little-endian.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_data`  out  32  extended load result.
- `resp_misaligned`  out  1  qualified by `resp_valid`.
- `resp_illegal`  out  1  qualified by `resp_valid`; set for funct3 011, 110, 111.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, register the address, funct3 and offset `off`=addr[1:0].
  - If the request is illegal, or misaligned (LH/LHU with off[0]=1; LW with off≠0), go to RESP with the matching flag set and `resp_data`=0. No memory access occurs.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - `mem_rd_en`=1 and `mem_addr` valid for exactly one cycle.
  - Load the latency counter with MEM_LATENCY-1.
  - Go to WAIT.
- **WAIT:**
  - Decrement the counter.
  - In the cycle the counter is 0, sample `mem_rd_data` and go to RESP.
- **Extraction (at sample time):**
  - Byte = data[8*off+7 : 8*off].
  - Half = data[16*off[1]+15 : 16*off[1]].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- **RESP:**
  - `resp_valid`=1 for one cycle with data and flags.
  - Go to IDLE.
- `resp_data` and the flags hold their values until the next RESP.
- `req_valid` outside IDLE is ignored. The requester must hold the request until it is accepted.
- `mem_addr` holds its last value when `mem_rd_en`=0.

## Timing
- All outputs are registered.
- **During reset (`reset`=0) at the edge:**
  - `req_ready`=0, `mem_rd_en`=0, `resp_valid`=0.
  - `resp_data`=0, flags=0, `mem_addr`=0.
  - State goes to IDLE.
- **After reset release:** `req_ready`=1 on the first edge with `reset`=1.
- **Normal load timeline:**
  - Request accepted at the end of cycle 0.
  - `mem_rd_en` is high in cycle 1.
  - Data is sampled at the end of cycle 1+MEM_LATENCY.
  - `resp_valid` is high in cycle 2+MEM_LATENCY.
  - `req_ready` returns in cycle 3+MEM_LATENCY.
- **Error path:** `resp_valid` in cycle 1, `req_ready` back in cycle 2; `mem_rd_en` is never asserted.
- **Throughput:** one load per 3+MEM_LATENCY cycles.
- **Reset mid-operation** (any state): the transaction is dropped.
  - No `resp_valid` is produced.
  - `mem_rd_en` goes low at the reset edge.
  - No data from an in-flight read is ever reported.
- Reset takes priority over a simultaneous `req_valid`.

## Test plan
- **Extraction:** memory word at 0x100 = 0x8081F2A5, MEM_LATENCY=1.
  - LB 0x100 -> 0xFFFFFFA5.
  - LBU 0x101 -> 0x000000F2.
  - LH 0x102 -> 0xFFFF8081.
  - LHU 0x100 -> 0x0000F2A5.
  - LW 0x100 -> 0x8081F2A5.
  - For each: `mem_addr`=0x100, `resp_valid` exactly 3 cycles after acceptance.
- **Latency sweep:** MEM_LATENCY=3, LW 0x104 (word 0xDEADBEEF).
  - `mem_rd_en` for one cycle, 1 cycle after acceptance.
  - `resp_valid` 5 cycles after acceptance, `resp_data`=0xDEADBEEF.
- **Misaligned:** LW 0x102 and LH 0x101.
  - `resp_valid` 1 cycle after acceptance, `resp_misaligned`=1, `resp_data`=0.
  - No `mem_rd_en` pulse.
- **Illegal:** funct3=011 at 0x100.
  - `resp_illegal`=1, `resp_misaligned`=0, no memory access.
- **Reset mid-load:** MEM_LATENCY=3, LW accepted, `reset`=0 in WAIT for 2 cycles.
  - No `resp_valid` ever appears.
  - All outputs are 0 during reset; `req_ready`=1 on the first edge after release.
  - A following LB 0x100 returns 0xFFFFFFA5.
- **Back-to-back:** `req_valid` held high with 3 queued requests.
  - Acceptances are spaced exactly 3+MEM_LATENCY cycles apart.
  - `req_ready`=0 while busy; responses arrive in order.
